// File: rtl/serial_adder_ctrl_if.sv
// ============================================================================
// serial_adder_ctrl_if : start/busy/done handshake and operand/result bundle
// Revision : 1.0 (SERIAL_ADDER_SUB_EN adds the sub select)
// ============================================================================
`default_nettype none

interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
// ============================================================================
// serial_adder_ctrl : bit-serial adder, one FA cell walked LSB-first over WIDTH
// Revision : 1.0 (SERIAL_ADDER_SUB_EN enables a - b via the sub select)
// ============================================================================
`default_nettype none

module FA (
    input  wire  i1,
    input  wire  i2,
    input  wire  i3,
    output logic sum,
    output logic carry
);
    assign sum   = i1 ^ i2 ^ i3;
    assign carry = (i1 & i2) | (i3 & (i1 ^ i2));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input wire                 clk,
    input wire                 rst_n,
    serial_adder_ctrl_if.slave bus
);
    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] sum_shifted;
    logic [WIDTH-1:0] load_b;
    logic             load_carry;
    logic             busy;
    logic             done;

    // Subtraction is a + ~b + 1, so only the loaded B and carry change.
`ifdef SERIAL_ADDER_SUB_EN
    assign load_b     = bus.sub ? ~bus.b : bus.b;
    assign load_carry = bus.sub | bus.cin;
`else
    assign load_b     = bus.b;
    assign load_carry = bus.cin;
`endif

    FA u_fa (
        .i1    (a_q[0]),
        .i2    (b_q[0]),
        .i3    (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign sum_shifted = fa_sum;
        end else begin : g_sum_wn
            assign sum_shifted = {fa_sum, sum_q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (cnt_q == CNT_LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // The carry register doubles as cout: it holds the final carry after RUN.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        if (state_q == S_IDLE && bus.start) begin
            a_d     = bus.a;
            b_d     = load_b;
            sum_d   = '0;
            carry_d = load_carry;
            cnt_d   = '0;
        end else if (state_q == S_RUN) begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            sum_d   = sum_shifted;
            carry_d = fa_carry;
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.sum  = sum_q;
    assign bus.cout = carry_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: WIDTH=8 vector table, random ops
// against an arithmetic model, handshake corner cases, and a WIDTH=1 instance.
`default_nettype none

module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();
    serial_adder_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_adder_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    serial_adder_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        string      name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic ci, input logic sb);
        int         total;
        logic [7:0] diff;
        if (sb) begin
            diff = a - b;
            return {(a >= b), diff};
        end
        total = int'(a) + int'(b) + (ci ? 1 : 0);
        return 9'(total);
    endfunction

    // Issues one op from IDLE; returns once done is seen (or the bound expires).
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                         input logic sb, output logic [7:0] s, output logic co,
                         output int lat, output int nbusy);
        bus.a   = a;
        bus.b   = b;
        bus.cin = ci;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub = sb;
`endif
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        lat   = 0;
        nbusy = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) nbusy++;
            tick();
            lat++;
        end
        s  = bus.sum;
        co = bus.cout;
    endtask

    task automatic op_and_check(input string name, input logic [7:0] a, input logic [7:0] b,
                                input logic ci, input logic sb,
                                input logic [7:0] es, input logic ec);
        logic [7:0] s;
        logic       co;
        int         lat;
        int         nbusy;
        do_op(a, b, ci, sb, s, co, lat, nbusy);
        check({name, "_latency"}, lat, W);
        check({name, "_busy_cycles"}, nbusy, W);
        check({name, "_sum"}, s, es);
        check({name, "_cout"}, co, ec);
        check({name, "_busy_at_done"}, bus.busy, 0);
        tick();
        check({name, "_done_clears"}, bus.done, 0);
        check({name, "_sum_held"}, bus.sum, es);
        check({name, "_cout_held"}, bus.cout, ec);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rc, rs;
        logic [8:0] exp;
        int         n_done;
        int         n_busy;

        vecs.push_back('{8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, "add_5a_33"});
        vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, "add_ff_01"});
        vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, "add_ff_ff_c"});
        vecs.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, "add_zero"});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, "add_80_80"});
        vecs.push_back('{8'h0F, 8'h01, 1'b1, 1'b0, 8'h11, 1'b0, "add_0f_01_c"});
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back('{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, "sub_10_01"});
        vecs.push_back('{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, "sub_00_01"});
        vecs.push_back('{8'h55, 8'h55, 1'b0, 1'b1, 8'h00, 1'b1, "sub_55_55"});
`endif

        bus.start  = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        bus.cin    = 1'b0;
        bus1.start = 1'b0;
        bus1.a     = '0;
        bus1.b     = '0;
        bus1.cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub    = 1'b0;
        bus1.sub   = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_sum", bus.sum, 0);
        check("reset_cout", bus.cout, 0);
        check("reset_w1_busy", bus1.busy, 0);
        check("reset_w1_sum", bus1.sum, 0);
        #2 rst_n = 1'b1;
        tick();

        foreach (vecs[i])
            op_and_check(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                         vecs[i].sum, vecs[i].cout);

        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            exp = model(ra, rb, rc, rs);
            op_and_check($sformatf("rand%0d", i), ra, rb, rc, rs, exp[7:0], exp[8]);
        end

        // start pulses during RUN and DONE must be ignored
        bus.a = 8'h5A; bus.b = 8'h33; bus.cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub = 1'b0;
`endif
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        check("ign_busy_k7", bus.busy, 1);
        check("ign_done_k7", bus.done, 0);
        bus.a = 8'h01;
        bus.start = 1'b1;
        tick();
        check("ign_done_k8", bus.done, 1);
        check("ign_sum_k8", bus.sum, 8'h8D);
        check("ign_cout_k8", bus.cout, 0);
        tick();
        bus.start = 1'b0;
        check("ign_done_k9", bus.done, 0);
        check("ign_busy_k9", bus.busy, 0);
        n_done = 0;
        n_busy = 0;
        repeat (12) begin
            tick();
            if (bus.done === 1'b1) n_done++;
            if (bus.busy === 1'b1) n_busy++;
        end
        check("ign_no_second_done", n_done, 0);
        check("ign_no_second_busy", n_busy, 0);
        check("ign_sum_held", bus.sum, 8'h8D);

        // asynchronous reset in the middle of an op
        bus.a = 8'hC3; bus.b = 8'h7E; bus.cin = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_sum", bus.sum, 0);
        check("midrst_cout", bus.cout, 0);
        #3 rst_n = 1'b1;
        tick();
        check("midrst_idle_busy", bus.busy, 0);
        op_and_check("after_rst", 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0);

        // WIDTH=1 instance
        bus1.a = 1'b1; bus1.b = 1'b1; bus1.cin = 1'b1;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        check("w1_busy_k", bus1.busy, 1);
        check("w1_done_k", bus1.done, 0);
        tick();
        check("w1_done_k1", bus1.done, 1);
        check("w1_busy_k1", bus1.busy, 0);
        check("w1_sum", bus1.sum, 1);
        check("w1_cout", bus1.cout, 1);
        tick();
        check("w1_done_clears", bus1.done, 0);
        check("w1_sum_held", bus1.sum, 1);
        bus1.a = 1'b1; bus1.b = 1'b0; bus1.cin = 1'b0;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        tick();
        check("w1b_done", bus1.done, 1);
        check("w1b_sum", bus1.sum, 1);
        check("w1b_cout", bus1.cout, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
